// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared definitions for the program counter unit: operation
//            encoding and default geometry of the address / return stack.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int DEFAULT_ADDR_W      = 16;
  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_INC    = 3'd1,
    OP_LOAD_L = 3'd2,
    OP_LOAD_H = 3'd3,
    OP_JREL   = 3'd4,
    OP_CALL   = 3'd5,
    OP_RET    = 3'd6,
    OP_RSVD   = 3'd7
  } pc_op_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack
// Purpose  : LIFO return-address stack for the program counter unit.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-low reset (clears entry count)
//            push       - write push_data on top (ignored when full)
//            pop        - drop top entry (ignored when empty)
//            push_data  - return address to store
//            top        - current top entry (zero when empty)
//            full/empty - derived from the registered entry count
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int                 COUNT_W = $clog2(STACK_DEPTH + 1);
  localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(STACK_DEPTH);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  mem_d [STACK_DEPTH];
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  // Push has priority; the parent never requests both in one cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty & ~push_ok;

  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push_ok) begin
      count_d = count_q + COUNT_W'(1);
    end else if (pop_ok) begin
      count_d = count_q - COUNT_W'(1);
    end
    // The free slot sits at index count_q.
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push_ok && (count_q == COUNT_W'(i))) begin
        mem_d[i] = push_data;
      end
    end
  end

  // Top of stack is the entry just below the count.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (count_q == COUNT_W'(i + 1)) begin
        top = mem_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage is only meaningful below the count, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : pc_stack
`default_nettype wire

// File: rtl/program_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : program_counter_unit
// Purpose  : Program counter with increment, byte-wise absolute load,
//            relative jump and call/return through a small return stack.
// Ports    : clk         - clock, rising edge
//            reset       - asynchronous active-low reset
//            op          - operation code (pc_op_e), sampled every edge
//            data_in     - byte operand (load byte, jump offset, call high)
//            pc          - registered program address
//            stack_full  - return stack holds STACK_DEPTH entries
//            stack_empty - return stack holds no entries
//            err         - sticky stack overflow / underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [7:0]        data_in,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        staging_q, staging_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] offset_sext;
  logic [ADDR_W-1:0] abs_target;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_push;
  logic              stack_pop;

  assign pc_plus1    = pc_q + ADDR_W'(1);
  assign offset_sext = {{(ADDR_W-8){data_in[7]}}, data_in};
  // High byte supplies only the bits above the staged low byte.
  assign abs_target  = {data_in[ADDR_W-9:0], staging_q};

  always_comb begin
    pc_d       = pc_q;
    staging_d  = staging_q;
    err_d      = err_q;
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    case (pc_op_e'(op))
      OP_INC:    pc_d = pc_plus1;
      OP_LOAD_L: staging_d = data_in;
      OP_LOAD_H: pc_d = abs_target;
      OP_JREL:   pc_d = pc_plus1 + offset_sext;
      OP_CALL: begin
        if (!stack_full) begin
          stack_push = 1'b1;
          pc_d       = abs_target;
        end else begin
          // Overflowing call degrades to a step over the instruction.
          pc_d  = pc_plus1;
          err_d = 1'b1;
        end
      end
      OP_RET: begin
        if (!stack_empty) begin
          stack_pop = 1'b1;
          pc_d      = stack_top;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= '0;
      staging_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      staging_q <= staging_d;
      err_q     <= err_d;
    end
  end

  pc_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stack_push),
    .pop       (stack_pop),
    .push_data (pc_plus1),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign pc  = pc_q;
  assign err = err_q;

endmodule : program_counter_unit
`default_nettype wire

// File: tb/tb_program_counter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_counter_unit
// Purpose  : Self-checking bench for program_counter_unit. A default-size
//            instance is checked against a behavioural model through an
//            expected-value queue; a 9-bit / depth-1 instance is checked
//            against a table of expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_counter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [7:0]  data_in;
  logic [15:0] pc;
  logic        stack_full, stack_empty, err;

  logic [2:0]  op1;
  logic [7:0]  data1;
  logic [8:0]  pc1;
  logic        full1, empty1, err1;

  always #5 clk = ~clk;

  program_counter_unit dut (
    .clk(clk), .reset(reset), .op(op), .data_in(data_in),
    .pc(pc), .stack_full(stack_full), .stack_empty(stack_empty), .err(err)
  );

  program_counter_unit #(.ADDR_W(9), .STACK_DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .op(op1), .data_in(data1),
    .pc(pc1), .stack_full(full1), .stack_empty(empty1), .err(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {pc, full, empty, err} per cycle.
  logic [18:0] sb  [$];
  logic [11:0] sb1 [$];

  // Behavioural model of the default-size instance.
  logic [15:0] m_pc;
  logic [7:0]  m_stg;
  logic [15:0] m_stack [$];
  logic        m_err;

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_stg = 8'h00;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] d);
    logic [15:0] nxt;
    op      = o;
    data_in = d;
    nxt     = m_pc + 16'd1;
    case (o)
      3'd1: m_pc = nxt;
      3'd2: m_stg = d;
      3'd3: m_pc = {d, m_stg};
      3'd4: m_pc = nxt + {{8{d[7]}}, d};
      3'd5: begin
        if (m_stack.size() < 4) begin
          m_stack.push_back(nxt);
          m_pc = {d, m_stg};
        end else begin
          m_pc  = nxt;
          m_err = 1'b1;
        end
      end
      3'd6: begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else m_err = 1'b1;
      end
      default: ;
    endcase
    sb.push_back({m_pc, (m_stack.size() == 4), (m_stack.size() == 0), m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [2:0] o, input logic [7:0] d, input logic [11:0] e);
    op1   = o;
    data1 = d;
    sb1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 3'd0; data_in = 8'h00; op1 = 3'd0; data1 = 8'h00;
    model_reset();
    #2;
    n_checks++;
    if ({pc, stack_full, stack_empty, err} !== {16'h0000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: {pc,full,empty,err} got %h expected %h",
               {pc, stack_full, stack_empty, err}, {16'h0000, 3'b010});
    end
    n_checks++;
    if ({pc1, full1, empty1, err1} !== {9'h000, 3'b010}) begin
      n_fail++;
      $display("FAIL reset_d1: {pc,full,empty,err} got %h expected %h",
               {pc1, full1, empty1, err1}, {9'h000, 3'b010});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_inc();
    logic [18:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 8'h00);
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL inc[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
    end
    n_checks++;
    if ({pc, stack_empty, err} !== {16'h0003, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL inc_x3: {pc,empty,err} got %h expected %h",
               {pc, stack_empty, err}, {16'h0003, 2'b10});
    end
  endtask

  task automatic test_wrap();
    logic [18:0] exp;
    logic [10:0] t [5];
    t = '{{3'd2, 8'hFF}, {3'd3, 8'hFF}, {3'd0, 8'h12}, {3'd7, 8'h34}, {3'd1, 8'h00}};
    for (int i = 0; i < 5; i++) begin
      drive(t[i][10:8], t[i][7:0]);
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL wrap[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
      if (i == 3) begin
        n_checks++;
        if (pc !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL wrap_top: pc got %h expected ffff", pc);
        end
      end
    end
    n_checks++;
    if (pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero: pc got %h expected 0000", pc);
    end
  endtask

  task automatic test_jrel();
    logic [18:0] exp;
    logic [10:0] t [4];
    t = '{{3'd2, 8'h00}, {3'd3, 8'h01}, {3'd4, 8'h80}, {3'd4, 8'h7F}};
    for (int i = 0; i < 4; i++) begin
      drive(t[i][10:8], t[i][7:0]);
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL jrel[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
      if (i == 2) begin
        n_checks++;
        if (pc !== 16'h0081) begin
          n_fail++;
          $display("FAIL jrel_back: pc got %h expected 0081", pc);
        end
      end
    end
    n_checks++;
    if (pc !== 16'h0101) begin
      n_fail++;
      $display("FAIL jrel_fwd: pc got %h expected 0101", pc);
    end
  endtask

  task automatic test_call_ret();
    logic [18:0] exp;
    logic [10:0] t [5];
    t = '{{3'd2, 8'h10}, {3'd3, 8'h00}, {3'd2, 8'h00}, {3'd5, 8'h20}, {3'd6, 8'h00}};
    for (int i = 0; i < 5; i++) begin
      drive(t[i][10:8], t[i][7:0]);
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
      if (i == 3) begin
        n_checks++;
        if ({pc, stack_empty} !== {16'h2000, 1'b0}) begin
          n_fail++;
          $display("FAIL call: {pc,empty} got %h expected %h", {pc, stack_empty}, {16'h2000, 1'b0});
        end
      end
    end
    n_checks++;
    if ({pc, stack_empty} !== {16'h0011, 1'b1}) begin
      n_fail++;
      $display("FAIL ret: {pc,empty} got %h expected %h", {pc, stack_empty}, {16'h0011, 1'b1});
    end
  endtask

  task automatic test_overflow();
    logic [18:0] exp;
    logic [10:0] t [11];
    t = '{{3'd2, 8'h40}, {3'd5, 8'h01}, {3'd5, 8'h02}, {3'd5, 8'h03}, {3'd5, 8'h04},
          {3'd5, 8'h05}, {3'd6, 8'h00}, {3'd6, 8'h00}, {3'd6, 8'h00}, {3'd6, 8'h00},
          {3'd6, 8'h00}};
    for (int i = 0; i < 11; i++) begin
      drive(t[i][10:8], t[i][7:0]);
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL overflow[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
      if (i == 5) begin
        n_checks++;
        if ({pc, stack_full, err} !== {16'h0441, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL call_full: {pc,full,err} got %h expected %h",
                   {pc, stack_full, err}, {16'h0441, 2'b11});
        end
      end
    end
    n_checks++;
    if ({pc, stack_empty, err} !== {16'h0012, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ret_empty: {pc,empty,err} got %h expected %h",
               {pc, stack_empty, err}, {16'h0012, 2'b11});
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(3'd5, 8'h10 + 8'(i));
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL mid_call[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
    end
    op = 3'd5; data_in = 8'h12;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pc, stack_full, stack_empty, err} !== {16'h0000, 3'b010}) begin
      n_fail++;
      $display("FAIL async_reset: {pc,full,empty,err} got %h expected %h",
               {pc, stack_full, stack_empty, err}, {16'h0000, 3'b010});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({pc, stack_full, stack_empty, err} !== {16'h0000, 3'b010}) begin
      n_fail++;
      $display("FAIL reset_hold: {pc,full,empty,err} got %h expected %h",
               {pc, stack_full, stack_empty, err}, {16'h0000, 3'b010});
    end
    op = 3'd0;
    #3;
    reset = 1'b1;
    model_reset();
    drive(3'd1, 8'h00);
    drive(3'd6, 8'h00);
    for (int i = 0; i < 2; i++) begin
      exp = sb.pop_front();
      n_checks++;
      if (i == 1 && {pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL post_reset: {pc,full,empty,err} got %h expected %h",
                 {pc, stack_full, stack_empty, err}, exp);
      end else if (i == 0 && exp !== {16'h0001, 3'b010}) begin
        n_fail++;
        $display("FAIL post_reset_model: expected %h required %h", exp, {16'h0001, 3'b010});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] exp;
    for (int i = 0; i < 60; i++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom));
      exp = sb.pop_front();
      n_checks++;
      if ({pc, stack_full, stack_empty, err} !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc, stack_full, stack_empty, err}, exp);
      end
    end
  endtask

  task automatic test_depth1();
    logic [11:0] exp;
    logic [22:0] t [9];
    op = 3'd0;
    t = '{{3'd2, 8'h34, 9'h000, 3'b010}, {3'd5, 8'h01, 9'h134, 3'b100},
          {3'd5, 8'h05, 9'h135, 3'b101}, {3'd6, 8'h00, 9'h001, 3'b011},
          {3'd6, 8'h00, 9'h001, 3'b011}, {3'd2, 8'hFF, 9'h001, 3'b011},
          {3'd3, 8'hFF, 9'h1FF, 3'b011}, {3'd1, 8'h00, 9'h000, 3'b011},
          {3'd4, 8'h80, 9'h181, 3'b011}};
    for (int i = 0; i < 9; i++) begin
      drive1(t[i][22:20], t[i][19:12], t[i][11:0]);
      exp = sb1.pop_front();
      n_checks++;
      if ({pc1, full1, empty1, err1} !== exp) begin
        n_fail++;
        $display("FAIL depth1[%0d]: {pc,full,empty,err} got %h expected %h",
                 i, {pc1, full1, empty1, err1}, exp);
      end
    end
    op1 = 3'd0;
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_jrel();
    test_call_ret();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_counter_unit
`default_nettype wire

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning program address width; legal range 9..16.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries; legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port op, input, 3 bits: operation code, sampled every rising edge.
REQ-006 The block SHALL have port data_in, input, 8 bits: byte operand for loads, offsets and call targets.
REQ-007 The block SHALL have port pc, output, ADDR_W bits: current program address, registered.
REQ-008 The block SHALL have port stack_full, output, 1 bit: the return stack holds STACK_DEPTH entries.
REQ-009 The block SHALL have port stack_empty, output, 1 bit: the return stack holds 0 entries.
REQ-010 The block SHALL have port err, output, 1 bit: sticky flag for stack overflow or underflow.

Function
REQ-011 op encodings SHALL be: 0 NOP, 1 INC, 2 LOAD_L, 3 LOAD_H, 4 JREL, 5 CALL, 6 RET, 7 NOP (reserved).
REQ-012 Every op SHALL take effect on the rising edge where it is sampled; pc, stack and flags SHALL be visible after that edge (1-cycle latency, no stalls).
REQ-013 NOP SHALL leave all state unchanged.
REQ-014 INC SHALL set pc to (pc+1) mod 2^ADDR_W; the all-ones address SHALL wrap to 0.
REQ-015 LOAD_L SHALL write data_in into an internal 8-bit staging register; pc SHALL be unchanged.
REQ-016 LOAD_H SHALL set pc to {data_in[ADDR_W-9:0], staging}; data_in bits above ADDR_W-9 SHALL be ignored.
REQ-017 JREL SHALL set pc to (pc + 1 + sign-extended data_in) mod 2^ADDR_W (range -128..+127 relative to the next address).
REQ-018 CALL with stack not full SHALL push (pc+1) mod 2^ADDR_W and set pc to {data_in[ADDR_W-9:0], staging}.
REQ-019 CALL with stack full SHALL neither push nor jump, SHALL set pc to (pc+1) mod 2^ADDR_W, and SHALL set err.
REQ-020 RET with stack not empty SHALL pop the top entry into pc.
REQ-021 RET with stack empty SHALL leave pc unchanged and SHALL set err.
REQ-022 The staging register SHALL be unchanged by every op other than LOAD_L.
REQ-023 stack_full and stack_empty SHALL be derived from the registered entry count and SHALL update on the same edge as the push or pop.
REQ-024 err SHALL remain 1 once set, until reset.
REQ-025 With STACK_DEPTH=1, stack_full and stack_empty SHALL be mutually exclusive, and a CALL followed by RET SHALL round-trip.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force pc=0, staging=0, stack count=0, stack_empty=1, stack_full=0 and err=0.
REQ-027 Stack entry contents SHALL NOT require reset; a reset asserted mid-operation SHALL discard the in-flight op.
REQ-028 The first op SHALL be sampled on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package pc_pkg SHALL hold the op encoding enum and the default ADDR_W and STACK_DEPTH constants.
REQ-030 The return stack SHALL be a sub-module pc_stack (LIFO; parameters ADDR_W and STACK_DEPTH; push, pop, top, full, empty).
REQ-031 pc_stack SHALL use the same clk and active-low asynchronous reset.

Verification
REQ-032 Reset, then INC x3 -> pc=0x0003, stack_empty=1, err=0.
REQ-033 LOAD_L 0xFF, LOAD_H 0xFF, INC -> pc=0xFFFF, then 0x0000 (wrap).
REQ-034 pc=0x0100, JREL 0x80 -> pc=0x0081; then JREL 0x7F -> pc=0x0101.
REQ-035 pc=0x0010, LOAD_L 0x00, CALL 0x20 -> pc=0x2000, stack_empty=0; RET -> pc=0x0011, stack_empty=1.
REQ-036 Five CALLs with STACK_DEPTH=4 -> fifth CALL gives stack_full=1, err=1, pc=previous+1; then five RETs -> fifth RET leaves pc unchanged and err stays 1.
REQ-037 Assert reset mid-CALL sequence with stack holding 2 entries -> pc=0, stack_empty=1, err=0 immediately, without waiting for a clock edge.
